// File: rtl/program_loader.sv
// Streams a block of words from a valid/ready source into RAM through the MAR/bus strobes.
// Define LOADER_VERIFY_EN to add a read-back compare state with a sticky err flag.
module program_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              pmode,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mar_load,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              ram_we,
  input  logic [DATA_W-1:0] bus_in,
  output logic              ram_oe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETADDR  = 3'd1,
    S_WAITDATA = 3'd2,
    S_WRITE    = 3'd3,
`ifdef LOADER_VERIFY_EN
    S_READBK   = 3'd4,
`endif
    S_DONE     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              next_word;
  logic              in_prog_d;

  logic              in_ready_q, in_ready_d;
  logic              pmode_q, pmode_d;
  logic [ADDR_W-1:0] mar_addr_q, mar_addr_d;
  logic              mar_load_q, mar_load_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              bus_oe_q, bus_oe_d;
  logic              ram_we_q, ram_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef LOADER_VERIFY_EN
  logic              ram_oe_q, ram_oe_d;
  logic              err_q, err_d;
`endif

  // Next state, datapath, and next value of every registered output.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    next_word = 1'b0;
`ifdef LOADER_VERIFY_EN
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          addr_d  = load_base;
          cnt_d   = load_len;
`ifdef LOADER_VERIFY_EN
          err_d   = 1'b0;
`endif
          state_d = (load_len == '0) ? S_DONE : S_SETADDR;
        end
      end
      S_SETADDR: state_d = S_WAITDATA;
      S_WAITDATA: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef LOADER_VERIFY_EN
        state_d = S_READBK;
`else
        next_word = 1'b1;
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_READBK: begin
        if (bus_in != data_q) err_d = 1'b1;
        next_word = 1'b1;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address wraps naturally at DEPTH through the ADDR_W-bit add.
    if (next_word) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_SETADDR;
      end
    end

    // Abort overrides every transition, including a same-cycle data transfer.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

    in_prog_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    pmode_d    = in_prog_d;
    busy_d     = in_prog_d;
    done_d     = (state_d == S_DONE);
    in_ready_d = (state_d == S_WAITDATA);
    mar_load_d = (state_d == S_SETADDR);
    mar_addr_d = (state_d == S_SETADDR) ? addr_d : '0;
    bus_oe_d   = (state_d == S_WRITE);
    ram_we_d   = (state_d == S_WRITE);
    bus_out_d  = (state_d == S_WRITE) ? data_d : '0;
`ifdef LOADER_VERIFY_EN
    ram_oe_d   = (state_d == S_READBK);
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      pmode_q    <= 1'b0;
      mar_addr_q <= '0;
      mar_load_q <= 1'b0;
      bus_out_q  <= '0;
      bus_oe_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LOADER_VERIFY_EN
      ram_oe_q   <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      pmode_q    <= pmode_d;
      mar_addr_q <= mar_addr_d;
      mar_load_q <= mar_load_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      ram_we_q   <= ram_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef LOADER_VERIFY_EN
      ram_oe_q   <= ram_oe_d;
      err_q      <= err_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign pmode    = pmode_q;
  assign mar_addr = mar_addr_q;
  assign mar_load = mar_load_q;
  assign bus_out  = bus_out_q;
  assign bus_oe   = bus_oe_q;
  assign ram_we   = ram_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef LOADER_VERIFY_EN
  assign ram_oe = ram_oe_q;
  assign err    = err_q;
`else
  // Read-back path absent: bus_in is intentionally ignored.
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
  assign ram_oe        = 1'b0;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader with a small MAR/RAM model on the bus side.
// Expected cycle counts adapt when LOADER_VERIFY_EN is defined.
module tb_program_loader;

`ifdef LOADER_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       load_start;
  logic [3:0] load_base;
  logic [4:0] load_len;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, pmode, mar_load, bus_oe, ram_we, ram_oe, busy, done, err;
  logic [3:0] mar_addr;
  logic [7:0] bus_out, bus_in;

  logic [7:0] ram [16];
  logic [3:0] mar_q;
  logic       ram_init;
  logic       corrupt;

  int total = 0;
  int bad   = 0;

  program_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .clr(clr), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pmode(pmode), .mar_addr(mar_addr), .mar_load(mar_load),
    .bus_out(bus_out), .bus_oe(bus_oe), .ram_we(ram_we), .bus_in(bus_in),
    .ram_oe(ram_oe), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'hC0;
  endfunction

  // MAR register plus RAM; address 1 can be made to read back inverted.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= pat(i);
    end else if (ram_we) begin
      ram[mar_q] <= bus_out;
    end
    if (mar_load) mar_q <= mar_addr;
  end

  assign bus_in = ram_oe ? (ram[mar_q] ^ ((corrupt && mar_q == 4'd1) ? 8'hFF : 8'h00)) : 8'h00;

  typedef struct {
    logic [3:0]        base;
    logic [4:0]        len;
    logic [0:15][7:0]  words;
    int                stall_word;
    int                stall;
    int                abort_word;
    logic              corrupt;
    int                exp_done;
    int                exp_we;
    int                exp_ready;
    logic              exp_err_v;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] outs_bits();
    return {pmode, busy, done, in_ready, mar_load, bus_oe, ram_we, ram_oe, mar_addr, bus_out};
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int wi, stall_left, done_cyc, end_cyc, nwe, nready, viol, nw, nbad, exp_done;
    logic xfer, ended_by_abort;
    logic [19:0] idle_bits;
    logic err_end;
    logic [7:0] exp_mem [16];

    @(posedge clk); #1;
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;
    corrupt  = v.corrupt;
    for (int i = 0; i < 16; i++) exp_mem[i] = pat(i);
    nw = (v.abort_word >= 0) ? v.abort_word : int'(v.len);
    for (int i = 0; i < nw; i++) exp_mem[4'(int'(v.base) + i)] = v.words[i];

    load_base  = v.base;
    load_len   = v.len;
    load_start = 1'b1;
    wi = 0; stall_left = v.stall;
    in_valid = (v.len > 0) && !(v.stall_word == 0 && stall_left > 0);
    in_data  = v.words[0];
    done_cyc = -1; end_cyc = -1; nwe = 0; nready = 0; viol = 0;
    ended_by_abort = 1'b0; idle_bits = '1; err_end = 1'bx;

    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (end_cyc >= 0 && cyc == end_cyc + 1) begin
        idle_bits = outs_bits();
        err_end   = err;
      end
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
        if (end_cyc < 0) end_cyc = cyc;
      end
      if (ram_we) nwe++;
      if (in_ready) nready++;
      if (!pmode && (in_ready || mar_load || bus_oe || ram_we || ram_oe)) viol++;
      if (int'(mar_load) + int'(ram_we) + int'(ram_oe) > 1) viol++;
      if (!bus_oe && bus_out != 8'h00) viol++;
      if (busy != pmode) viol++;
      xfer = in_valid && in_ready;
      if (in_ready && !in_valid && stall_left > 0 && wi == v.stall_word) stall_left--;
      if (v.abort_word >= 0 && in_ready && wi == v.abort_word && end_cyc < 0) begin
        abort = 1'b1;
        end_cyc = cyc;
        ended_by_abort = 1'b1;
        xfer = 1'b0;
      end
      if (end_cyc >= 0 && cyc >= end_cyc + (ended_by_abort ? 4 : 1)) break;
      @(posedge clk); #1;
      load_start = 1'b0;
      abort      = 1'b0;
      if (xfer) wi++;
      in_valid = (wi < int'(v.len)) && !(wi == v.stall_word && stall_left > 0);
      in_data  = (wi < 16) ? v.words[wi] : 8'h00;
    end
    load_start = 1'b0;
    abort      = 1'b0;
    in_valid   = 1'b0;

    nbad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== exp_mem[i]) nbad++;
    exp_done = (v.exp_done >= 0) ? v.exp_done + VER * int'(v.len) : -1;

    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " ram_we_count"}, nwe, v.exp_we);
    check({tag, " in_ready_cycles"}, nready, v.exp_ready);
    check({tag, " ram_bad_words"}, nbad, 0);
    check({tag, " strobe_violations"}, viol, 0);
    check({tag, " idle_after_end"}, 32'(idle_bits), 0);
    check({tag, " err_at_end"}, 32'(err_end), (VER != 0) ? 32'(v.exp_err_v) : 0);
  endtask

  initial begin
    int seen;
    clr = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; ram_init = 1'b0; corrupt = 1'b0;

    //           base   len    words (index 0 first)                                 stW stall abW corr done we rdy errV
    vecs[0] = '{4'hE, 5'd6,  {8'h38,8'h23,8'h1E,8'h2F,8'hE0,8'hF0,80'h0},          -1, 0, -1, 1'b0, 19,  6,  6, 1'b0};
    vecs[1] = '{4'h3, 5'd0,  128'h0,                                                -1, 0, -1, 1'b0,  1,  0,  0, 1'b0};
    vecs[2] = '{4'h5, 5'd4,  {8'hA1,8'hB2,8'hC3,8'hD4,96'h0},                         1, 5, -1, 1'b0, 18,  4,  9, 1'b0};
    vecs[3] = '{4'hF, 5'd2,  {8'h11,8'h22,112'h0},                                   -1, 0, -1, 1'b0,  7,  2,  2, 1'b0};
    vecs[4] = '{4'h2, 5'd5,  {8'h5A,8'h6B,8'h7C,8'h8D,8'h9E,88'h0},                 -1, 0,  2, 1'b0, -1,  2,  3, 1'b0};
    vecs[5] = '{4'h0, 5'd3,  {8'h10,8'h20,8'h30,104'h0},                             -1, 0, -1, 1'b1, 10,  3,  3, 1'b1};
    vecs[6] = '{4'h8, 5'd16, {8'h01,8'h12,8'h23,8'h34,8'h45,8'h56,8'h67,8'h78,
                              8'h89,8'h9A,8'hAB,8'hBC,8'hCD,8'hDE,8'hEF,8'hF0},     -1, 0, -1, 1'b0, 49, 16, 16, 1'b0};

    @(negedge clk);
    check("reset_outputs", {11'h0, err, outs_bits()}, 0);
    @(negedge clk);
    clr = 1'b0;

    for (int k = 0; k < 7; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Asynchronous clear in the middle of a WRITE cycle.
    @(posedge clk); #1;
    load_base = 4'h0; load_len = 5'd3; load_start = 1'b1;
    in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    load_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_oe) seen = 1;
    end
    check("clr_write_reached", seen, 1);
    clr = 1'b1;
    #1;
    check("clr_async_outputs", {11'h0, err, outs_bits()}, 0);
    in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("clr_no_resume", seen, 0);

    run_vec("post_clr", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
